// File: rtl/seq_slice_adder_ctrl_if.sv
// rtl/seq_slice_adder_ctrl_if.sv - issue/writeback bundle for the sliced add/subtract controller
//
// Purpose: groups the issue handshake, operands and held result of
//          seq_slice_adder_ctrl so the issuing unit and the controller
//          connect through one port.
// Optional macro: ADDER_CARRY_CHAIN_EN adds the 1-bit chain request.
// Signals:
//   start, a, b, cin, sub, chain  issuer -> controller
//   ready, busy, done             controller -> issuer (status/pulse)
//   sum, cout, ovf                controller -> issuer (held result)
// Modports: master = issuing unit, slave = controller.

interface seq_slice_adder_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
`ifdef ADDER_CARRY_CHAIN_EN
    logic             chain;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
`ifdef ADDER_CARRY_CHAIN_EN
        output chain,
`endif
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
`ifdef ADDER_CARRY_CHAIN_EN
        input  chain,
`endif
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_slice_adder_ctrl.sv
// rtl/seq_slice_adder_ctrl.sv - multi-cycle add/subtract reusing one SLICE-bit adder slice
//
// Purpose: forms a WIDTH-bit A+B+cin or A-B over NSLICE cycles, LSB slice
//          first, with a start/ready issue handshake and a one-cycle done
//          pulse. sum/cout/ovf are held from done until the next accept.
// Optional macro: ADDER_CARRY_CHAIN_EN - with chain=1 at accept, the carry-in
//          is the cout of the previous completed operation (multi-word add).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seq_slice_adder_ctrl_if.slave (start/a/b/cin/sub[/chain] in,
//        ready/busy/done/sum/cout/ovf out)

module seq_slice_adder_ctrl #(
    parameter  int WIDTH  = 64,
    parameter  int SLICE  = 16,
    localparam int NSLICE = WIDTH / SLICE
) (
    input  logic                         clk,
    input  logic                         rst,
    seq_slice_adder_ctrl_if.slave        bus
);
    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;
    logic             busy_q;
    logic             ready_q;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE:0]   slice_full;
    logic             carry_into_msb;
    logic             carry_in_sel;
    logic             last_slice;

    always_comb begin
        slice_a    = op_a[int'(idx)*SLICE +: SLICE];
        slice_b    = op_b[int'(idx)*SLICE +: SLICE];
        slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry};
        // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out by XOR.
        carry_into_msb = slice_full[SLICE-1] ^ slice_a[SLICE-1] ^ slice_b[SLICE-1];
        last_slice     = (idx == IDXW'(NSLICE - 1));
    end

    // cout_q only changes on the last slice edge (or reset), so it always holds
    // the carry of the previous completed operation.
    always_comb begin
        carry_in_sel = bus.sub ? 1'b1 : bus.cin;
`ifdef ADDER_CARRY_CHAIN_EN
        if (bus.chain) begin
            carry_in_sel = cout_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a    <= bus.a;
                        op_b    <= bus.sub ? ~bus.b : bus.b;
                        carry   <= carry_in_sel;
                        idx     <= '0;
                        state   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[int'(idx)*SLICE +: SLICE] <= slice_full[SLICE-1:0];
                    carry <= slice_full[SLICE];
                    if (last_slice) begin
                        cout_q <= slice_full[SLICE];
                        ovf_q  <= slice_full[SLICE] ^ carry_into_msb;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// tb/tb_seq_slice_adder_ctrl.sv - self-checking bench for seq_slice_adder_ctrl

module tb_seq_slice_adder_ctrl;
    localparam int WIDTH  = 64;
    localparam int NSLICE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    logic model_cout = 1'b0;

    always #5 clk = ~clk;

    seq_slice_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    seq_slice_adder_ctrl #(.WIDTH(WIDTH), .SLICE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub, input logic chain,
                                               input logic prev_cout);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        logic             c;
        logic             v;
        bb = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        if (chain) c = prev_cout;
        full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
        v = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {v, full};
    endfunction

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input logic chain);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        bus.sub = sub;
`ifdef ADDER_CARRY_CHAIN_EN
        bus.chain = chain;
`else
        if (chain) bus.cin = cin;
`endif
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input logic chain);
        logic [WIDTH+1:0] exp;
        logic             use_chain;
        int               n;
`ifdef ADDER_CARRY_CHAIN_EN
        use_chain = chain;
`else
        use_chain = 1'b0;
`endif
        exp = model(a, b, cin, sub, use_chain, model_cout);
        @(negedge clk);
        drive(a, b, cin, sub, chain);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, {64'd0, bus.busy}, 65'd1);
        // Operands must already be latched; scramble the inputs.
        drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 65'(n), 65'(NSLICE));
        check({tag, "_sum"}, {1'b0, bus.sum}, {1'b0, exp[WIDTH-1:0]});
        check({tag, "_cout"}, {64'd0, bus.cout}, {64'd0, exp[WIDTH]});
        check({tag, "_ovf"}, {64'd0, bus.ovf}, {64'd0, exp[WIDTH+1]});
        model_cout = exp[WIDTH];
        @(posedge clk);
        #1;
        check({tag, "_ready_after"}, {63'd0, bus.ready, bus.done}, 65'd2);
    endtask

    initial begin
        int n;
        logic seen_low;
        logic [WIDTH-1:0] first_sum;
        bus.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_status", {62'd0, bus.ready, bus.busy, bus.done}, 65'd4);
        check("rst_sum", {1'b0, bus.sum}, 65'd0);
        check("rst_flags", {63'd0, bus.cout, bus.ovf}, 65'd0);

        // Directed arithmetic
        run_op("cross_slice", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        run_op("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 1'b0);
        run_op("add_cin", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("rand%0d", i), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom), 1'($urandom), 1'b0);
        end

        // start pulsed mid-RUN with zero operands is ignored
        @(negedge clk);
        drive(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ignore_latency", 65'(n), 65'(NSLICE - 2));
        check("ignore_sum", {1'b0, bus.sum}, 65'd7);
        repeat (3) @(negedge clk);
        check("ignore_no_reaccept", {63'd0, bus.ready, bus.busy}, 65'd2);

        // rst on the 2nd RUN cycle aborts with no done pulse
        @(negedge clk);
        drive(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cout = 1'b0;
        check("abort_status", {62'd0, bus.ready, bus.busy, bus.done}, 65'd4);
        check("abort_sum", {1'b0, bus.sum}, 65'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check("abort_no_done", 65'(n), 65'd0);

        // rst and start together: rst wins
        @(negedge clk);
        drive(64'd9, 64'd9, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start_ready", {63'd0, bus.ready, bus.busy}, 65'd2);

        // Back-to-back with start held high
        @(negedge clk);
        drive(64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        drive(64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
        n = 0;
        seen_low = 1'b0;
        first_sum = '1;
        while (!(seen_low && bus.busy) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) first_sum = bus.sum;
            if (!bus.busy) seen_low = 1'b1;
        end
        bus.start = 1'b0;
        check("b2b_spacing", 65'(n), 65'(NSLICE + 2));
        check("b2b_first_sum", {1'b0, first_sum}, 65'd3);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_second_sum", {1'b0, bus.sum}, 65'd30);
        model_cout = bus.done ? 1'b0 : 1'b1;
        model_cout = 1'b0;

`ifdef ADDER_CARRY_CHAIN_EN
        run_op("chain_op1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        run_op("chain_op2", 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        check("chain_op2_sum1", {1'b0, bus.sum}, 65'd1);
        run_op("chain_op1b", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cout = 1'b0;
        run_op("chain_after_rst", 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        check("chain_after_rst_sum0", {1'b0, bus.sum}, 65'd0);
        run_op("chain_sub", 64'd5, 64'd5, 1'b0, 1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seq_slice_adder_ctrl.md
Name: seq_slice_adder_ctrl

Overview:
- Multi-cycle add/subtract controller that reuses one SLICE-bit adder slice over NSLICE cycles to form a WIDTH-bit result.
- Used where a full-width combinational ripple adder is too slow or too large.
- Sits between an issuing unit (start/ready handshake) and the register file writeback (done pulse plus held result).

Parameters:
- WIDTH, 64, operand and result width.
- SLICE, 16, bits computed per cycle. WIDTH must be an integer multiple of SLICE.
- NSLICE, WIDTH/SLICE, derived: number of compute cycles. Not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add mode.
- sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1, cin ignored).
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  carry out of the MSB; for subtraction 1 = no borrow.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when slice index = NSLICE-1.
  - DONE -> IDLE unconditionally.
- Reset values: state=IDLE, slice index=0, carry reg=0, sum=0, cout=0, ovf=0, done=0, busy=0, ready=1.
- Accept edge (IDLE, start=1):
  - Latch a into operand reg; latch (sub ? ~b : b) into operand reg.
  - Carry reg <= (sub ? 1 : cin). Slice index <= 0. sum is not cleared.
- Each RUN edge:
  - Slice i = bits [i*SLICE +: SLICE] = opA_i + opB_i + carry reg; write into sum slice i.
  - Carry reg <= slice carry-out; index++.
  - Slices are processed LSB first.
- Last slice edge also writes cout and ovf, taken from the MSB slice's internal carries, and sets done=1.
- Latency: done is high during the cycle following edge k+NSLICE, where k is the accept edge (NSLICE=4 gives 4 edges). ready returns on the edge after done.
- Throughput: one operation per NSLICE+2 cycles. start held high through DONE is sampled again in the following IDLE cycle.
- start while RUN or DONE is ignored. The latched operands are unaffected by a/b/cin/sub changing mid-operation.
- sum, cout and ovf are intermediate (partially updated) during RUN. They are valid and stable from the done cycle until the next accept edge.
- rst during RUN or DONE:
  - Next cycle is IDLE with all reset values.
  - No done pulse occurs for the aborted operation.
- rst and start in the same cycle: rst wins; the operation is not accepted.
- Width rules: all arithmetic is modulo 2^WIDTH; carry-out beyond the MSB is reported only via cout.

Optional Feature:
- ADDER_CARRY_CHAIN_EN defined:
  - Adds input port `chain` (1 bit).
  - At the accept edge with chain=1 and sub=0, carry reg <= stored cout of the previous completed operation instead of cin. This enables multi-word (e.g. 128-bit) additions.
  - Stored cout is cleared by rst.
  - chain with sub=1 uses the stored cout as the no-borrow carry-in instead of 1.
- Undefined: port absent; carry-in selection is exactly as described in Behaviour.

Test Plan:
- Reset: rst=1 for 2 cycles then 0 -> ready=1, busy=0, done=0, sum=0, cout=0, ovf=0.
- Cross-slice carry: a=0x00000000FFFFFFFF, b=0x1, cin=0, sub=0 -> done exactly 4 edges after accept; sum=0x0000000100000000, cout=0, ovf=0.
- Full wrap: a=0xFFFFFFFFFFFFFFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0.
- Subtract:
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFFFFFFFFFE, cout=0.
  - a=0x8000000000000000, b=1, sub=1 -> sum=0x7FFFFFFFFFFFFFFF, cout=1, ovf=1.
- Protocol:
  - start pulsed during RUN with a=b=0 is ignored; the first result (a=3, b=4 -> 7) is delivered.
  - rst asserted on the 2nd RUN cycle -> IDLE next cycle, no done pulse, sum=0.
  - Back-to-back: start held high -> second accept occurs NSLICE+2 cycles after the first.
- ADDER_CARRY_CHAIN_EN: op1 a=0xFFFFFFFFFFFFFFFF, b=1 -> cout=1; op2 a=0, b=0, chain=1 -> sum=1, cout=0. Repeat op2 after rst -> sum=0.
